// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end.
// Owns the fetch PC and issues word requests to instruction memory, accepting
// responses in order. Fetched {insn, pc} pairs go into a small circular queue
// so decode can stall. A redirect restarts fetch, flushes the queue and marks
// every still-outstanding response to be dropped.
module fetch_stage #(
    parameter int                ADDR_W      = 32,
    parameter int                QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_stall,
    output logic [31:0]       insn,
    output logic [ADDR_W-1:0] pc,
    output logic              insn_valid
);
    localparam int          PW      = $clog2(QUEUE_DEPTH);
    localparam int          CW      = $clog2(QUEUE_DEPTH + 1);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(QUEUE_DEPTH);

    typedef struct packed {
        logic [31:0]       insn;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            q_mem [QUEUE_DEPTH];
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [ADDR_W-1:0] last_pc_q;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW:0]       credits_used;
    logic [ADDR_W-1:0] redirect_base;
    logic              issue, push, pop;

    // Request side, queue head outputs and per-cycle handshake events.
    // In-flight requests and queued entries share one credit pool, so a
    // response can always be pushed; a pop this cycle does not free a credit.
    always_comb begin
        credits_used   = {1'b0, inflight_q} + {1'b0, count_q};
        imem_req_valid = rst && !redirect_valid && (credits_used < DEPTH_C);
        imem_req_addr  = fetch_pc_q;
        issue          = imem_req_valid && imem_req_ready;
        // A response is kept only when nothing is pending to be dropped and
        // no redirect is discarding this cycle's data.
        push           = imem_resp_valid && (drop_q == '0) && !redirect_valid;
        insn_valid     = (count_q != '0);
        pop            = insn_valid && !id_stall;
        insn           = insn_valid ? q_mem[rd_ptr_q].insn : NOP;
        // pc holds the last presented address while the queue is empty.
        pc             = insn_valid ? q_mem[rd_ptr_q].pc : last_pc_q;
        redirect_base  = redirect_pc & ~ADDR_W'(3);
    end

    // Next-state for PCs, credit counters and queue pointers; redirect wins.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q + CW'(issue) - CW'(imem_resp_valid);
        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            resp_pc_d  = redirect_base;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // Everything still outstanding after this cycle belongs to the
            // old path; this cycle's response is already discarded.
            drop_d     = inflight_q - CW'(imem_resp_valid);
        end else begin
            if (issue)
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            if (imem_resp_valid && (drop_q != '0))
                drop_d = drop_q - CW'(1);
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                resp_pc_d = resp_pc_q + ADDR_W'(4);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            last_pc_q  <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            last_pc_q  <= pc;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage; contents are only visible while count is nonzero,
    // so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push)
            q_mem[wr_ptr_q] <= '{insn: imem_resp_data, pc: resp_pc_q};
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end that produces the `insn` and `pc` stream consumed by the decode stage. It owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel, and accepts in-order responses. Fetched instructions are buffered in a small queue so decode can stall without losing data. A branch/jump redirect restarts fetch and discards all stale in-flight and queued instructions.

Parameters:
ADDR_W, 32, width of the instruction address path
QUEUE_DEPTH, 4, instruction queue entries; also the maximum of in-flight plus queued instructions (power of 2, at least 2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word address of request
imem_resp_valid  in  1  response valid; in order; no backpressure
imem_resp_data  in  32  instruction word
redirect_valid  in  1  branch/jump taken, restart fetch
redirect_pc  in  ADDR_W  redirect target
id_stall  in  1  decode cannot accept this cycle
insn  out  32  instruction to decode
pc  out  ADDR_W  address of insn
insn_valid  out  1  insn/pc valid

Behaviour:
- State: fetch_pc, resp_pc, inflight counter (0..QUEUE_DEPTH), drop_cnt (0..QUEUE_DEPTH), circular queue of {insn, pc} with count.
- Reset (rst=0, asynchronous): fetch_pc=resp_pc=RESET_PC; inflight=drop_cnt=count=0; imem_req_valid=0; insn_valid=0; insn=32'h0000_0013 (NOP); pc=0. The instruction memory must be reset with this block, because responses to pre-reset requests are not filtered.
- imem_req_addr = fetch_pc.
- imem_req_valid = !redirect_valid && (inflight + count < QUEUE_DEPTH). This is registered-state based, except that redirect_valid suppresses it combinationally. A pop in the same cycle does not free a credit.
- Issue = imem_req_valid && imem_req_ready:
  - fetch_pc += 4, modulo 2^ADDR_W.
  - inflight += 1.
- Response (imem_resp_valid):
  - inflight -= 1 in all cases.
  - If drop_cnt > 0: drop_cnt -= 1 and the data is discarded.
  - Otherwise push {imem_resp_data, resp_pc} and resp_pc += 4.
  - Issue and response in the same cycle leave inflight unchanged.
- The credit rule guarantees a push never hits a full queue. A push when full is a bench assertion failure.
- Output: insn/pc come from the queue head; insn_valid = (count != 0). When the queue is empty, insn = NOP and pc holds its last value.
- Pop = insn_valid && !id_stall. Push and pop in the same cycle leave count unchanged. Read and write pointers wrap at QUEUE_DEPTH.
- Latency: a request accepted in cycle N with a response in cycle N+L shows insn_valid in cycle N+L+1 when the queue was empty (registered queue output). Steady-state throughput is 1 insn/cycle for L=1 with no stall.
- Redirect (redirect_valid=1) has highest priority and applies regardless of id_stall:
  - Next cycle: fetch_pc = resp_pc = {redirect_pc[ADDR_W-1:2], 2'b00} (low bits forced to 0).
  - Queue flushed: count=0 and pointers reset, so insn_valid=0 in the next cycle.
  - drop_cnt = inflight - imem_resp_valid. Any response arriving in the redirect cycle is discarded, and inflight is updated normally.
  - No request is issued in the redirect cycle. Fetch resumes the next cycle when credits allow, and credits still count to-be-dropped in-flight requests.
- Back-to-back redirects: each one reapplies all of the above. The last target wins.
- A stall with a full queue holds the outputs stable and issues no requests.

Test Plan:
- Reset then free run, memory L=1, imem_req_ready=1, imem word = address: `pc` sequence 0,4,8,12 with insn_valid continuous from cycle 3 onward, and insn == pc.
- Hold id_stall=1 for 10 cycles: at most 4 requests are outstanding-plus-queued, imem_req_valid drops, and insn/pc stay constant. On release, the outputs resume at the next sequential pc with no skipped or duplicated pc.
- Memory L=3 with 3 in flight, redirect_valid=1 to 0x100: the 3 late responses are dropped, the first valid output has pc=0x100, and no pre-redirect pc appears.
- Redirect to 0x203 in the same cycle as a response and a pop: the response is discarded, the next fetch address is 0x200, and insn_valid=0 in the next cycle.
- Assert rst=0 mid-stream with a queue holding 3 entries: outputs clear immediately (asynchronously), and after release the first request address is RESET_PC.
- Start at 0xFFFF_FFF8 via redirect: the `pc` sequence wraps FFFF_FFF8, FFFF_FFFC, 0000_0000.
